l2_request_buffer: RTL and testbench
====================================

# l2_request_buffer

Downstream stage of the cache controller (`PROJECT`). It accepts the 26-bit line-address requests the controller produces on `add_out` and buffers them in a small FIFO. It issues them one at a time to the next-level (L2) memory model over a req/ack handshake, and returns a one-cycle `done` pulse to the controller when a fill-type request completes. Per-type request counters support end-of-trace statistics printing.

## Interface
Parameters:
- `ADDR_W`, 26: line-address width; matches the controller's `add_out`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the statistics counters.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  — system clock, rising edge.
- `clear_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — controller presents a request.
- `req_op`  in  2  — 00 READ, 01 WRITE, 10 RWIM, 11 reserved.
- `req_addr`  in  ADDR_W  — line address (controller `add_out`).
- `req_ready`  out  1  — FIFO not full; a request is accepted when `req_valid & req_ready` at a rising edge.
- `l2_req`  out  1  — request to L2, held until acknowledged.
- `l2_op`  out  2  — op of the outstanding request.
- `l2_addr`  out  ADDR_W  — address of the outstanding request.
- `l2_ack`  in  1  — L2 completion, sampled at the rising edge.
- `done`  out  1  — one-cycle pulse: a READ or RWIM completed (drives controller `done`).
- `busy`  out  1  — FIFO non-empty or a request is outstanding.
- `err`  out  1  — sticky: a reserved op was presented.
- `rd_count`, `wr_count`, `rwim_count`  out  CNT_W each — completed requests per type.

## Operation
- Reset values: `req_ready`=1; all other outputs 0. FIFO is emptied and FSM state is IDLE.
- Push: on `req_valid & req_ready` with op≠11, write {op,addr} at the tail.
  - op=11 is not pushed; it sets `err` and is acknowledged (consumed) normally.
- `req_ready` = !full, computed from registered occupancy only. A pop in the same cycle does not free space early.
- FSM states:
  - IDLE: if FIFO non-empty, register the head into `l2_op`/`l2_addr`, set `l2_req`=1, go to REQ. Otherwise stay.
  - REQ: hold `l2_req`, `l2_op`, `l2_addr` stable. On `l2_ack`=1:
    - clear `l2_req` and pop the head;
    - increment the counter for that op;
    - pulse `done` if the op is READ or RWIM;
    - return to IDLE.
- `l2_ack` while in IDLE is ignored.
- Push and pop in the same cycle: both take effect; occupancy is unchanged.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is distinguished by an occupancy counter of log2(DEPTH)+1 bits.
- Counters saturate at all-ones and do not wrap.
- `err` clears only on reset.

## Timing
- Request accepted into an empty FIFO at edge N → `l2_req`=1 after edge N+1.
- `l2_ack` sampled at edge M → `l2_req`=0 and `done`=1 for the cycle after M. The counter is updated at edge M.
- One-cycle IDLE bubble between requests: next `l2_req` rises after edge M+1 at the earliest.
- Back-to-back throughput is one request per 2 + (L2 wait) cycles.
- `clear_n` asserted mid-transaction: `l2_req`, `done`, and the counters drop to 0 immediately (asynchronously), and FIFO contents are discarded. After release, the first edge behaves as after power-up.

## Structure
- Package `l2_buf_pkg`:
  - op encodings `OP_READ`, `OP_WRITE`, `OP_RWIM`, `OP_RSVD` as a 2-bit typedef;
  - FSM state typedef {IDLE, REQ};
  - default `ADDR_W` constant.
- Sub-module `sync_fifo`: parameterised width/depth, push/pop/full/empty/count, async active-low reset. It is instantiated once with width 2+ADDR_W.
- The FSM, output registers, counters, and `err` live in the top module.

## Test plan
- Single READ 0x0ABCDEF with `l2_ack` returned 3 cycles after `l2_req` rises → `l2_addr`=0x0ABCDEF held for 3 cycles, one `done` pulse, `rd_count`=1, `busy` falls the cycle after the ack.
- Push 5 WRITEs back-to-back with DEPTH=4 and L2 stalled → `req_ready`=0 after the 4th accept, 5th held off. Release ack → issue order matches push order, `wr_count`=5, no `done` pulses.
- Push on the same edge as a pop while full → the push is rejected (`req_ready` was 0), occupancy stays 4 → 3 → … with no loss or duplication.
- op=11 at 0x0000001 → `err`=1, nothing issued to L2, no counter change, `err` stays set across later traffic.
- Assert `clear_n` while in REQ with 3 entries queued → all outputs 0 asynchronously. After release a new RWIM 0x3FFFFFF issues normally, `rwim_count`=1.
- Preload `CNT_W`=2 and complete 5 READs → `rd_count` saturates at 3.

Source files
------------

// File: rtl/l2_request_buffer_pkg.sv
// Shared types and constants for the L2 request buffer.
package l2_buf_pkg;

    localparam int L2_ADDR_W = 26;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_RWIM  = 2'b10,
        OP_RSVD  = 2'b11
    } l2_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } l2_state_e;

    // READ and RWIM bring a line back to the controller, so they complete with done.
    function automatic logic is_fill(input l2_op_e op);
        return (op == OP_READ) || (op == OP_RWIM);
    endfunction

endpackage

// File: rtl/l2_request_buffer_if.sv
// Controller-side request bus and L2-side handshake of the request buffer.
interface l2_request_buffer_if #(
    parameter int ADDR_W = l2_buf_pkg::L2_ADDR_W,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              l2_req;
    logic [1:0]        l2_op;
    logic [ADDR_W-1:0] l2_addr;
    logic              l2_ack;
    logic              done;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  wr_count;
    logic [CNT_W-1:0]  rwim_count;

    modport master (
        output req_valid, req_op, req_addr, l2_ack,
        input  req_ready, l2_req, l2_op, l2_addr, done, busy, err,
               rd_count, wr_count, rwim_count
    );

    modport slave (
        input  req_valid, req_op, req_addr, l2_ack,
        output req_ready, l2_req, l2_op, l2_addr, done, busy, err,
               rd_count, wr_count, rwim_count
    );
endinterface

// File: rtl/l2_request_buffer_sync_fifo.sv
// Small synchronous FIFO with occupancy counter; head is readable without a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset discards contents by emptying the pointers.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; no reset needed since empty entries are never read out.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/l2_request_buffer.sv
// Buffers controller line requests and issues them one at a time to L2.
module l2_request_buffer
    import l2_buf_pkg::*;
#(
    parameter int ADDR_W = L2_ADDR_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                clear_n,
    l2_request_buffer_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);

    l2_state_e         state_q, state_d;
    logic              l2_req_q, l2_req_d;
    l2_op_e            l2_op_q, l2_op_d;
    logic [ADDR_W-1:0] l2_addr_q, l2_addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rwim_cnt_q, rwim_cnt_d;

    logic [ADDR_W+1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PTR_W:0]    fifo_count;
    logic              push;
    logic              pop;
    logic              accept;

    assign accept = bus.req_valid && !fifo_full;
    assign push   = accept && (bus.req_op != OP_RSVD);
    assign pop    = (state_q == REQ) && bus.l2_ack;

    sync_fifo #(
        .WIDTH (ADDR_W + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .clear_n (clear_n),
        .push    (push),
        .pop     (pop),
        .din     ({bus.req_op, bus.req_addr}),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Issue/complete FSM with registered L2 outputs and saturating statistics.
    always_comb begin
        state_d    = state_q;
        l2_req_d   = l2_req_q;
        l2_op_d    = l2_op_q;
        l2_addr_d  = l2_addr_q;
        done_d     = 1'b0;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;
        rwim_cnt_d = rwim_cnt_q;
        err_d      = err_q || (accept && (bus.req_op == OP_RSVD));
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    l2_op_d   = l2_op_e'(fifo_dout[ADDR_W+1:ADDR_W]);
                    l2_addr_d = fifo_dout[ADDR_W-1:0];
                    l2_req_d  = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (bus.l2_ack) begin
                    l2_req_d = 1'b0;
                    done_d   = is_fill(l2_op_q);
                    state_d  = IDLE;
                    case (l2_op_q)
                        OP_READ:  if (rd_cnt_q != '1)   rd_cnt_d   = rd_cnt_q + CNT_W'(1);
                        OP_WRITE: if (wr_cnt_q != '1)   wr_cnt_d   = wr_cnt_q + CNT_W'(1);
                        OP_RWIM:  if (rwim_cnt_q != '1) rwim_cnt_d = rwim_cnt_q + CNT_W'(1);
                        default:  ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= IDLE;
            l2_req_q   <= 1'b0;
            l2_op_q    <= OP_READ;
            l2_addr_q  <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            rwim_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            l2_req_q   <= l2_req_d;
            l2_op_q    <= l2_op_d;
            l2_addr_q  <= l2_addr_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            rwim_cnt_q <= rwim_cnt_d;
        end
    end

    assign bus.req_ready  = !fifo_full;
    assign bus.l2_req     = l2_req_q;
    assign bus.l2_op      = l2_op_q;
    assign bus.l2_addr    = l2_addr_q;
    assign bus.done       = done_q;
    assign bus.busy       = (fifo_count != '0) || l2_req_q;
    assign bus.err        = err_q;
    assign bus.rd_count   = rd_cnt_q;
    assign bus.wr_count   = wr_cnt_q;
    assign bus.rwim_count = rwim_cnt_q;
endmodule

// File: tb/tb_l2_request_buffer.sv
// Bench for l2_request_buffer: two instances (16-bit and 2-bit counters) share
// stimulus and are checked every cycle against a queue-based behavioural model.
module tb_l2_request_buffer;
    localparam int ADDR_W = 26;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
    } ent_t;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    always #5 clk = ~clk;

    l2_request_buffer_if #(.ADDR_W(ADDR_W), .CNT_W(16)) bus_a ();
    l2_request_buffer_if #(.ADDR_W(ADDR_W), .CNT_W(2))  bus_b ();

    assign bus_b.req_valid = bus_a.req_valid;
    assign bus_b.req_op    = bus_a.req_op;
    assign bus_b.req_addr  = bus_a.req_addr;
    assign bus_b.l2_ack    = bus_a.l2_ack;

    l2_request_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(16)) dut_a (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus_a)
    );

    l2_request_buffer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(2)) dut_b (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus_b)
    );

    int errors = 0;
    int checks = 0;

    // Behavioural model: queue of pending requests (head stays until completed).
    ent_t        mq[$];
    bit          m_out;
    bit          m_done;
    bit          m_err;
    int unsigned m_cnt[3];
    logic [ADDR_W-1:0] issued[$];
    int          done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int unsigned c, input int w);
        int unsigned mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_out  = 0;
        m_done = 0;
        m_err  = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":ready"}, 32'(bus_a.req_ready), 32'(mq.size() < DEPTH));
        chk({ph, ":l2_req"}, 32'(bus_a.l2_req), 32'(m_out));
        if (m_out && mq.size() > 0) begin
            chk({ph, ":l2_addr"}, 32'(bus_a.l2_addr), 32'(mq[0].addr));
            chk({ph, ":l2_op"}, 32'(bus_a.l2_op), 32'(mq[0].op));
        end
        chk({ph, ":done"}, 32'(bus_a.done), 32'(m_done));
        chk({ph, ":busy"}, 32'(bus_a.busy), 32'(mq.size() > 0 || m_out));
        chk({ph, ":err"}, 32'(bus_a.err), 32'(m_err));
        chk({ph, ":rd_a"}, 32'(bus_a.rd_count), sat(m_cnt[0], 16));
        chk({ph, ":wr_a"}, 32'(bus_a.wr_count), sat(m_cnt[1], 16));
        chk({ph, ":rwim_a"}, 32'(bus_a.rwim_count), sat(m_cnt[2], 16));
        chk({ph, ":rd_b"}, 32'(bus_b.rd_count), sat(m_cnt[0], 2));
        chk({ph, ":wr_b"}, 32'(bus_b.wr_count), sat(m_cnt[1], 2));
        chk({ph, ":rwim_b"}, 32'(bus_b.rwim_count), sat(m_cnt[2], 2));
        chk({ph, ":l2_req_b"}, 32'(bus_b.l2_req), 32'(m_out));
        if (bus_a.done) done_seen++;
    endtask

    // One clock: drive inputs, advance the model by the edge rules, check outputs.
    task automatic cycle(input string ph, input bit v, input logic [1:0] op,
                         input logic [ADDR_W-1:0] a, input bit ack);
        bit   acc;
        ent_t e;
        bus_a.req_valid = v;
        bus_a.req_op    = op;
        bus_a.req_addr  = a;
        bus_a.l2_ack    = ack;
        acc = v && (mq.size() < DEPTH);
        @(posedge clk);
        m_done = 0;
        if (m_out && ack) begin
            e = mq.pop_front();
            m_cnt[e.op]++;
            m_done = (e.op != 2'b01);
            m_out  = 0;
        end else if (!m_out && mq.size() > 0) begin
            m_out = 1;
            issued.push_back(mq[0].addr);
        end
        if (acc) begin
            if (op == 2'b11) m_err = 1;
            else begin
                e.op = op;
                e.addr = a;
                mq.push_back(e);
            end
        end
        #1;
        check_all(ph);
    endtask

    task automatic drain(input string ph);
        for (int i = 0; i < 40 && (mq.size() > 0 || m_out); i++)
            cycle(ph, 0, 2'b00, '0, 1);
        chk({ph, ":drained"}, 32'(mq.size() > 0 || m_out), 32'd0);
    endtask

    initial begin
        logic [ADDR_W-1:0] wr_addrs[5];
        int                k;
        bit                v;
        logic [1:0]        op;

        bus_a.req_valid = 0;
        bus_a.req_op    = 2'b00;
        bus_a.req_addr  = '0;
        bus_a.l2_ack    = 0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("reset");
        clear_n = 1;

        // Single READ, ack returned after l2_req has been high 3 cycles.
        cycle("rd1", 1, 2'b00, 26'h0ABCDEF, 0);
        for (int i = 0; i < 3; i++) cycle("rd1_wait", 0, 2'b00, '0, 0);
        cycle("rd1_ack", 0, 2'b00, '0, 1);
        chk("rd1_done_pulse", 32'(bus_a.done), 32'd1);
        chk("rd1_count", 32'(bus_a.rd_count), 32'd1);
        cycle("rd1_after", 0, 2'b00, '0, 0);
        chk("rd1_busy_low", 32'(bus_a.busy), 32'd0);

        // Five WRITEs with L2 stalled; fifth waits for space.
        issued.delete();
        done_seen = 0;
        for (int i = 0; i < 5; i++) wr_addrs[i] = 26'(32'h100 + i * 32'h11);
        k = 0;
        for (int i = 0; i < 12 && k < 5; i++) begin
            v = 1;
            if (mq.size() < DEPTH) begin
                cycle("wr_fill", v, 2'b01, wr_addrs[k], 0);
                k++;
            end else cycle("wr_full", v, 2'b01, wr_addrs[k], 0);
            if (k == 4) begin
                chk("wr_ready_low", 32'(bus_a.req_ready), 32'd0);
                cycle("wr_held", 1, 2'b01, wr_addrs[4], 0);
            end
        end
        // Keep offering the fifth while acking; it enters only once space frees.
        for (int i = 0; i < 10 && k < 5; i++) begin
            if (mq.size() < DEPTH) begin
                cycle("wr_push5", 1, 2'b01, wr_addrs[4], 1);
                k++;
            end else cycle("wr_pop_full", 1, 2'b01, wr_addrs[4], 1);
        end
        drain("wr_drain");
        chk("wr_issue_cnt", 32'(issued.size()), 32'd5);
        for (int i = 0; i < 5 && i < issued.size(); i++)
            chk($sformatf("wr_order%0d", i), 32'(issued[i]), 32'(wr_addrs[i]));
        chk("wr_count5", 32'(bus_a.wr_count), 32'd5);
        chk("wr_no_done", 32'(done_seen), 32'd0);

        // Reserved op: sets err, nothing issued.
        issued.delete();
        cycle("rsvd", 1, 2'b11, 26'h0000001, 0);
        cycle("rsvd_w1", 0, 2'b00, '0, 1);
        cycle("rsvd_w2", 0, 2'b00, '0, 0);
        chk("rsvd_err", 32'(bus_a.err), 32'd1);
        chk("rsvd_no_issue", 32'(issued.size()), 32'd0);
        cycle("rsvd_wr", 1, 2'b01, 26'h0000002, 0);
        drain("rsvd_drain");
        chk("err_sticky", 32'(bus_a.err), 32'd1);

        // Asynchronous clear while in REQ with three queued.
        for (int i = 0; i < 3; i++) cycle("clr_fill", 1, 2'(i), 26'(32'h2000 + i), 0);
        bus_a.req_valid = 0;
        #2;
        clear_n = 0;
        #1;
        model_reset();
        check_all("arst_now");
        @(posedge clk);
        #1;
        check_all("arst_hold");
        clear_n = 1;
        cycle("rwim", 1, 2'b10, 26'h3FFFFFF, 0);
        cycle("rwim_w", 0, 2'b00, '0, 0);
        chk("rwim_addr", 32'(bus_a.l2_addr), 32'h3FFFFFF);
        cycle("rwim_ack", 0, 2'b00, '0, 1);
        chk("rwim_count", 32'(bus_a.rwim_count), 32'd1);
        chk("rwim_done", 32'(bus_a.done), 32'd1);

        // Five READs: 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            cycle("sat_push", 1, 2'b00, 26'(32'h40 + i), 0);
            drain("sat_drain");
        end
        chk("sat_rd_b", 32'(bus_b.rd_count), 32'd3);
        chk("sat_rd_a", 32'(bus_a.rd_count), 32'd5);

        // Randomized traffic including reserved ops and acks while idle.
        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            cycle("rand", 1'($urandom_range(0, 1)), op, 26'($urandom),
                  ($urandom_range(0, 2) == 0));
        end
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
